// File: rtl/labfinalsoc_pio_pkg.sv
// Shared constants for the key/switch interrupt PIO: register addresses and edge-type encodings.
package labfinalsoc_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/labfinalsoc_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by an optional debouncer.
// Debouncer is built only when DEBOUNCE_EN is defined; otherwise stable follows the synchroniser.
module labfinalsoc_debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter bit IDLE_LEVEL      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    end

    // Reset to the idle level so releasing reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // Any cycle where sync agrees with stable restarts the count, rejecting short glitches.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= IDLE_LEVEL;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;
`else
    assign stable = sync;
`endif

endmodule

// File: rtl/labfinalsoc_key_irq_pio.sv
// Avalon-MM input PIO with per-bit edge capture, interrupt mask and level irq.
// Optional per-bit debouncing is enabled by defining DEBOUNCE_EN.
module labfinalsoc_key_irq_pio
    import labfinalsoc_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam bit               IDLE_BIT = 1'(IDLE_LEVEL);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_BIT}};

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      rd_word;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            labfinalsoc_debounce_bit #(
                .SYNC_STAGES    (SYNC_STAGES),
                .IDLE_LEVEL     (IDLE_BIT),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk   (clk),
                .reset (reset),
                .pin   (in_port[gi]),
                .stable(stable[gi])
            );
        end

        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: detect = stable & ~prev_q;
            EDGE_FALL: detect = ~stable & prev_q;
            default:   detect = stable ^ prev_q;
        endcase
    end

    always_comb begin
        wr_en  = chipselect & ~write_n;
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && (address == ADDR_EDGE)) begin
            clr = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        // OR-ing detect in last means a same-cycle edge beats the clear.
        edge_d = (edge_q & ~clr) | detect;
        prev_d = stable;
    end

    // Read mux is not gated by chipselect; bits above WIDTH read as zero.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word[WIDTH-1:0] = stable;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_q;
            default:   rd_word = '0;
        endcase
        readdata_d = rd_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= IDLE_VEC;
            edge_q     <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule
